input_unit: RTL
===============

INPUT_UNIT -- requirements
Module: input_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, flit payload width in bits.
REQ-002 SHALL have parameter ROUTER_ADDR_WIDTH, default 4, destination address width; equal to the router-wide address width used by the switch allocator.
REQ-003 SHALL have parameter DEPTH, default 4, buffer entries; power of two, >= 2.
REQ-004 SHALL use one clock and a reset that is synchronous and active-high; ports clk, rst.
REQ-005 Ports, as name direction width meaning:
  clk  input  1  rising-edge clock
  rst  input  1  synchronous active-high reset
  in_valid  input  1  upstream flit valid
  in_data  input  DATA_WIDTH  upstream flit payload
  in_addr  input  ROUTER_ADDR_WIDTH  upstream flit destination address
  in_ready  output  1  buffer can accept a flit this cycle
  dst_ready  input  1  selected output port can take a flit; gates the request
  sa_request  output  1  switch-allocation request for the head flit
  sa_addr  output  ROUTER_ADDR_WIDTH  head flit address, for lowest-address arbitration
  sa_grant  input  1  allocator grant for this port
  st_valid  output  1  switch-traversal flit valid
  st_data  output  DATA_WIDTH  switch-traversal payload
  st_addr  output  ROUTER_ADDR_WIDTH  switch-traversal address
  occupancy  output  clog2(DEPTH)+1  entries currently held

Function
REQ-006 SHALL store flits in a DEPTH-entry circular FIFO: read/write pointers clog2(DEPTH) bits wrapping modulo DEPTH, plus a count register 0..DEPTH.
REQ-007 SHALL drive in_ready = (count < DEPTH), combinational from registered count only; no dependence on sa_grant (no full-bypass).
REQ-008 SHALL push when in_valid && in_ready: write {in_data,in_addr} at write pointer, advance write pointer at the clock edge.
REQ-009 SHALL drive sa_request = (count != 0) && dst_ready; sa_addr = head entry address whenever count != 0, all-zero when empty.
REQ-010 SHALL pop only when sa_grant && sa_request; a grant while sa_request is low is ignored with no state change.
REQ-011 SHALL register the popped head into st_data/st_addr and assert st_valid for exactly one cycle, the cycle after the grant (1-cycle grant-to-traversal latency).
REQ-012 SHALL deassert st_valid on any cycle with no pop; st_data/st_addr hold their last values.
REQ-013 SHALL, on simultaneous push and pop, keep count unchanged and advance both pointers.
REQ-014 SHALL provide no empty-bypass: a flit pushed into an empty buffer raises sa_request no earlier than the next cycle.
REQ-015 SHALL drive occupancy = count.
REQ-016 SHALL support back-to-back pops: with sustained grant and dst_ready, one flit per cycle, st_valid held high.
REQ-017 SHALL preserve FIFO order across pointer wrap-around.

Reset
REQ-018 SHALL, while rst is high at a clock edge, clear pointers and count to 0, st_valid to 0, st_data and st_addr to 0.
REQ-019 SHALL discard all buffered flits on reset mid-operation; a push or grant in the reset cycle is ignored.
REQ-020 SHALL, in the first cycle after reset, show in_ready=1, sa_request=0, occupancy=0.
REQ-021 Buffer storage need not be reset.

Verification
REQ-022 Single flit: push data=0xA5, addr=3 into empty unit, dst_ready=1 -> next cycle sa_request=1, sa_addr=3; grant -> following cycle st_valid=1, st_data=0xA5, st_addr=3, occupancy=0.
REQ-023 Fill: push 4 flits addr 1..4 with no grant -> occupancy=4, in_ready=0; a 5th in_valid is not accepted; sa_addr=1.
REQ-024 Full with simultaneous push+pop: occupancy=4, grant and in_valid same cycle -> flit not accepted, occupancy=3, in_ready=1 next cycle.
REQ-025 Wrap-around: stream 10 flits data 0..9 with sustained grant and continuous push -> st_data emitted 0..9 in order, no loss or duplication.
REQ-026 Gating: occupancy=2, dst_ready=0, sa_grant=1 -> sa_request=0, no pop, st_valid=0; raise dst_ready -> pop resumes.
REQ-027 Reset mid-stream: occupancy=3, assert rst one cycle -> occupancy=0, st_valid=0, sa_request=0; old flits never appear on st_data.

Source files
------------

// File: rtl/input_unit.sv
// Router input unit: DEPTH-entry flit FIFO with a switch-allocation request
// towards the allocator and a registered switch-traversal output stage.
module input_unit #(
    parameter int DATA_WIDTH        = 32,
    parameter int ROUTER_ADDR_WIDTH = 4,
    parameter int DEPTH             = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic [ROUTER_ADDR_WIDTH-1:0] in_addr,
    output logic                         in_ready,
    input  logic                         dst_ready,
    output logic                         sa_request,
    output logic [ROUTER_ADDR_WIDTH-1:0] sa_addr,
    input  logic                         sa_grant,
    output logic                         st_valid,
    output logic [DATA_WIDTH-1:0]        st_data,
    output logic [ROUTER_ADDR_WIDTH-1:0] st_addr,
    output logic [$clog2(DEPTH):0]       occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0]        data_mem [DEPTH];
    logic [ROUTER_ADDR_WIDTH-1:0] addr_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic empty;
    logic push;
    logic pop;

    // Handshake decode: everything here depends on registered state plus
    // the current-cycle inputs, so a fresh flit cannot request until the
    // cycle after it is written.
    always_comb begin
        empty      = (count == '0);
        in_ready   = (count < FULL_COUNT);
        sa_request = !empty && dst_ready;
        sa_addr    = empty ? '0 : addr_mem[rd_ptr];
        push       = in_valid && in_ready;
        pop        = sa_request && sa_grant;
        occupancy  = count;
    end

    // Storage is not reset; pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            data_mem[wr_ptr] <= in_data;
            addr_mem[wr_ptr] <= in_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Switch-traversal stage: one cycle after the grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_valid <= 1'b0;
            st_data  <= '0;
            st_addr  <= '0;
        end else if (pop) begin
            st_valid <= 1'b1;
            st_data  <= data_mem[rd_ptr];
            st_addr  <= addr_mem[rd_ptr];
        end else begin
            st_valid <= 1'b0;
        end
    end

endmodule
